// File: rtl/multi_car_renderer_pkg.sv
// Shared definitions for the multi-car renderer.
//  - Colour constants NEGRO..BLANCO ({R,G,B}).
//  - Default sprite dimensions.
//  - slot_rec_t: per-slot register layout (shadow and active copies).
//  - car_pixel(): sprite colour lookup used by car_memory.
// Build option: CAR_FLIP_EN adds a horizontal-flip bit to each slot record.
package multi_car_renderer_pkg;

  localparam logic [2:0] NEGRO    = 3'd0;
  localparam logic [2:0] AZUL     = 3'd1;
  localparam logic [2:0] VERDE    = 3'd2;
  localparam logic [2:0] CIAN     = 3'd3;
  localparam logic [2:0] ROJO     = 3'd4;
  localparam logic [2:0] MAGENTA  = 3'd5;
  localparam logic [2:0] AMARILLO = 3'd6;
  localparam logic [2:0] BLANCO   = 3'd7;

  localparam int unsigned CAR_WIDTH_DEF  = 16;
  localparam int unsigned CAR_HEIGHT_DEF = 32;

  typedef struct packed {
`ifdef CAR_FLIP_EN
    logic       flip;
`endif
    logic       visible;
    logic [2:0] owner;
    logic [9:0] y;
    logic [7:0] x;
  } slot_rec_t;

  // Sprite art: a diagonal colour ramp driven by the owner and the top three bits of
  // each local coordinate, so every owner and orientation looks distinct.
  function automatic logic [2:0] car_pixel(logic [2:0] owner, logic [2:0] lx_hi,
                                           logic [2:0] ly_hi);
    logic [2:0] idx;
    logic [2:0] col;
    idx = owner + lx_hi + ly_hi;
    unique case (idx)
      3'd0:    col = NEGRO;
      3'd1:    col = AZUL;
      3'd2:    col = VERDE;
      3'd3:    col = CIAN;
      3'd4:    col = ROJO;
      3'd5:    col = MAGENTA;
      3'd6:    col = AMARILLO;
      default: col = BLANCO;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/car_memory.sv
// Sprite ROM with a one-cycle registered read.
// Ports: pclk, reset (async, active-high); owner selects the sprite; local_x/local_y address
// the texel inside it; rgb is the registered colour. Sprite dimensions must be >= 8 px.
module car_memory
  import multi_car_renderer_pkg::*;
#(
  parameter int unsigned CAR_WIDTH  = CAR_WIDTH_DEF,
  parameter int unsigned CAR_HEIGHT = CAR_HEIGHT_DEF
) (
  input  logic                          pclk,
  input  logic                          reset,
  input  logic [2:0]                    owner,
  input  logic [$clog2(CAR_WIDTH)-1:0]  local_x,
  input  logic [$clog2(CAR_HEIGHT)-1:0] local_y,
  output logic [2:0]                    rgb
);

  localparam int unsigned LX_W = $clog2(CAR_WIDTH);
  localparam int unsigned LY_W = $clog2(CAR_HEIGHT);

  logic [2:0] lx_hi;
  logic [2:0] ly_hi;

  assign lx_hi = 3'(local_x >> (LX_W - 3));
  assign ly_hi = 3'(local_y >> (LY_W - 3));

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      rgb <= NEGRO;
    end else begin
      rgb <= car_pixel(owner, lx_hi, ly_hi);
    end
  end

endmodule

// File: rtl/car_slot_match.sv
// One car slot: shadow/active registers plus the combinational hit test.
// Ports: pclk, reset (async, active-high); frame_start commits shadow -> active; wr_en/wr_rec
// load the shadow copy; pixel_x/pixel_y is the pixel under test; hit/local_x/local_y/owner
// describe this slot's coverage of that pixel.
// Build option: CAR_FLIP_EN mirrors local_x for slots with the flip bit set.
module car_slot_match
  import multi_car_renderer_pkg::*;
#(
  parameter int unsigned CAR_WIDTH   = CAR_WIDTH_DEF,
  parameter int unsigned CAR_HEIGHT  = CAR_HEIGHT_DEF,
  parameter int unsigned ROAD_X_BASE = 256
) (
  input  logic                          pclk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          wr_en,
  input  slot_rec_t                     wr_rec,
  input  logic [9:0]                    pixel_x,
  input  logic [9:0]                    pixel_y,
  output logic                          hit,
  output logic [$clog2(CAR_WIDTH)-1:0]  local_x,
  output logic [$clog2(CAR_HEIGHT)-1:0] local_y,
  output logic [2:0]                    owner
);

  localparam int unsigned LX_W = $clog2(CAR_WIDTH);
  localparam int unsigned LY_W = $clog2(CAR_HEIGHT);
  localparam logic [1:0]  ROAD_HI = 2'(ROAD_X_BASE >> 8);

  slot_rec_t shadow_q;
  slot_rec_t active_q;

  // Active copy only moves at frame start, so a frame is always drawn from one snapshot.
  // A write in the frame_start cycle lands in shadow only (active takes the old shadow).
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en) shadow_q <= wr_rec;
      if (frame_start) active_q <= shadow_q;
    end
  end

  logic [7:0]      road_x;
  logic            in_x;
  logic            in_y;
  logic [LX_W-1:0] dx;

  assign road_x = pixel_x[7:0];
  // Widened compares: right edge past column 255 and bottom edge past row 1023 never wrap.
  assign in_x = ({1'b0, road_x} >= {1'b0, active_q.x}) &&
                ({1'b0, road_x} < ({1'b0, active_q.x} + 9'(CAR_WIDTH)));
  assign in_y = ({1'b0, pixel_y} >= {1'b0, active_q.y}) &&
                ({1'b0, pixel_y} < ({1'b0, active_q.y} + 11'(CAR_HEIGHT)));
  assign hit  = active_q.visible && (pixel_x[9:8] == ROAD_HI) && in_x && in_y;

  assign dx      = LX_W'(road_x - active_q.x);
  assign local_y = LY_W'(pixel_y - active_q.y);
  assign owner   = active_q.owner;

`ifdef CAR_FLIP_EN
  // Width is a power of two, so WIDTH-1-dx is a bitwise inversion.
  assign local_x = active_q.flip ? ~dx : dx;
`else
  assign local_x = dx;
`endif

endmodule

// File: rtl/multi_car_renderer.sv
// N-slot car sprite renderer.
// Ports: pclk, reset (async, active-high); pixel_x/pixel_y current pixel; frame_start first-pixel
// pulse; wr_en/wr_slot/wr_x/wr_y/wr_owner/wr_visible shadow-register write; rgb/on/hit_slot the
// rendered pixel two edges after presentation; collision_mask/collision the previous frame's
// car-car overlaps.
// Build option: CAR_FLIP_EN adds input wr_flip and per-slot horizontal mirroring.
module multi_car_renderer
  import multi_car_renderer_pkg::*;
#(
  parameter int unsigned NUM_CARS    = 4,
  parameter int unsigned CAR_WIDTH   = CAR_WIDTH_DEF,
  parameter int unsigned CAR_HEIGHT  = CAR_HEIGHT_DEF,
  parameter int unsigned ROAD_X_BASE = 256,
  localparam int unsigned SLOT_W     = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
  input  logic                pclk,
  input  logic                reset,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic                frame_start,
  input  logic                wr_en,
  input  logic [SLOT_W-1:0]   wr_slot,
  input  logic [7:0]          wr_x,
  input  logic [9:0]          wr_y,
  input  logic [2:0]          wr_owner,
  input  logic                wr_visible,
`ifdef CAR_FLIP_EN
  input  logic                wr_flip,
`endif
  output logic [2:0]          rgb,
  output logic                on,
  output logic [SLOT_W-1:0]   hit_slot,
  output logic [NUM_CARS-1:0] collision_mask,
  output logic                collision
);

  localparam int unsigned LX_W = $clog2(CAR_WIDTH);
  localparam int unsigned LY_W = $clog2(CAR_HEIGHT);

  slot_rec_t wr_rec;
  always_comb begin
    wr_rec         = '0;
    wr_rec.x       = wr_x;
    wr_rec.y       = wr_y;
    wr_rec.owner   = wr_owner;
    wr_rec.visible = wr_visible;
`ifdef CAR_FLIP_EN
    wr_rec.flip    = wr_flip;
`endif
  end

  logic [NUM_CARS-1:0] hits;
  logic [LX_W-1:0]     lx_arr    [NUM_CARS];
  logic [LY_W-1:0]     ly_arr    [NUM_CARS];
  logic [2:0]          owner_arr [NUM_CARS];

  for (genvar s = 0; s < NUM_CARS; s++) begin : g_slot
    car_slot_match #(
      .CAR_WIDTH  (CAR_WIDTH),
      .CAR_HEIGHT (CAR_HEIGHT),
      .ROAD_X_BASE(ROAD_X_BASE)
    ) u_match (
      .pclk       (pclk),
      .reset      (reset),
      .frame_start(frame_start),
      .wr_en      (wr_en && (int'(wr_slot) == s)),
      .wr_rec     (wr_rec),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .hit        (hits[s]),
      .local_x    (lx_arr[s]),
      .local_y    (ly_arr[s]),
      .owner      (owner_arr[s])
    );
  end

  // Lowest-index hitting slot wins: scan downwards so the last assignment is the lowest.
  logic              win_any;
  logic [SLOT_W-1:0] win_slot;
  logic [LX_W-1:0]   win_lx;
  logic [LY_W-1:0]   win_ly;
  logic [2:0]        win_owner;

  always_comb begin
    win_any   = 1'b0;
    win_slot  = '0;
    win_lx    = '0;
    win_ly    = '0;
    win_owner = '0;
    for (int i = int'(NUM_CARS) - 1; i >= 0; i--) begin
      if (hits[i]) begin
        win_any   = 1'b1;
        win_slot  = SLOT_W'(i);
        win_lx    = lx_arr[i];
        win_ly    = ly_arr[i];
        win_owner = owner_arr[i];
      end
    end
  end

  // Stage 1.
  logic [NUM_CARS-1:0] hit_q;
  logic                any_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [LX_W-1:0]     lx_q;
  logic [LY_W-1:0]     ly_q;
  logic [2:0]          owner_q;
  // Stage 2 (car_memory supplies the registered colour).
  logic                on_q;
  logic [SLOT_W-1:0]   hit_slot_q;
  logic [2:0]          mem_rgb;
  // Collision tracking.
  logic [NUM_CARS-1:0] acc_q;
  logic [NUM_CARS-1:0] mask_q;
  logic                multi;

  assign multi = ($countones(hit_q) >= 2);

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hit_q      <= '0;
      any_q      <= 1'b0;
      slot_q     <= '0;
      lx_q       <= '0;
      ly_q       <= '0;
      owner_q    <= '0;
      on_q       <= 1'b0;
      hit_slot_q <= '0;
      acc_q      <= '0;
      mask_q     <= '0;
    end else begin
      hit_q      <= hits;
      any_q      <= win_any;
      slot_q     <= win_slot;
      lx_q       <= win_lx;
      ly_q       <= win_ly;
      owner_q    <= win_owner;
      on_q       <= any_q;
      hit_slot_q <= slot_q;
      if (frame_start) begin
        // Fold in this cycle's overlap too, so the last pixel of the frame is not lost.
        mask_q <= acc_q | (multi ? hit_q : '0);
        acc_q  <= '0;
      end else if (multi) begin
        acc_q <= acc_q | hit_q;
      end
    end
  end

  car_memory #(
    .CAR_WIDTH (CAR_WIDTH),
    .CAR_HEIGHT(CAR_HEIGHT)
  ) u_car_memory (
    .pclk   (pclk),
    .reset  (reset),
    .owner  (owner_q),
    .local_x(lx_q),
    .local_y(ly_q),
    .rgb    (mem_rgb)
  );

  assign rgb            = on_q ? mem_rgb : NEGRO;
  assign on             = on_q;
  assign hit_slot       = hit_slot_q;
  assign collision_mask = mask_q;
  assign collision      = |mask_q;

endmodule

// File: tb/tb_multi_car_renderer.sv
// Self-checking bench for multi_car_renderer: constant-expectation vector table, hand-written
// multi-cycle sequences and randomized frames checked against a rectangle-based reference model.
module tb_multi_car_renderer;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int H  = 32;
  localparam int RB = 256;

  logic       pclk = 1'b0;
  logic       reset;
  logic [9:0] pixel_x, pixel_y;
  logic       frame_start, wr_en;
  logic [1:0] wr_slot;
  logic [7:0] wr_x;
  logic [9:0] wr_y;
  logic [2:0] wr_owner;
  logic       wr_visible;
  logic [2:0] rgb;
  logic       on;
  logic [1:0] hit_slot;
  logic [3:0] collision_mask;
  logic       collision;
`ifdef CAR_FLIP_EN
  logic       wr_flip;
  bit         m_wflip = 1'b0;
`endif

  multi_car_renderer #(
    .NUM_CARS   (N),
    .CAR_WIDTH  (W),
    .CAR_HEIGHT (H),
    .ROAD_X_BASE(RB)
  ) dut (
    .pclk          (pclk),
    .reset         (reset),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .frame_start   (frame_start),
    .wr_en         (wr_en),
    .wr_slot       (wr_slot),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_owner      (wr_owner),
    .wr_visible    (wr_visible),
`ifdef CAR_FLIP_EN
    .wr_flip       (wr_flip),
`endif
    .rgb           (rgb),
    .on            (on),
    .hit_slot      (hit_slot),
    .collision_mask(collision_mask),
    .collision     (collision)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: slot rectangles, a per-frame overlap set, and the expected pixel
  // output for the last two presented pixels.
  int m_sx[N], m_sy[N], m_so[N], m_ax[N], m_ay[N], m_ao[N];
  bit m_sv[N], m_sf[N], m_av[N], m_af[N];
  bit [N-1:0] m_acc, m_mask, m_prev;
  bit e1_on, e2_on;
  int e1_slot, e1_rgb, e2_slot, e2_rgb;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit covers(int s, int px, int py);
    int rx;
    rx = px - RB;
    return m_av[s] && rx >= 0 && rx < 256 && rx >= m_ax[s] && rx < m_ax[s] + W &&
           py >= m_ay[s] && py < m_ay[s] + H;
  endfunction

  task automatic model_pixel(input int px, input int py, output bit o_on, output int o_slot,
                             output int o_rgb, output bit [N-1:0] o_hits);
    int lx, ly;
    o_on = 0; o_slot = 0; o_rgb = 0; o_hits = '0;
    for (int s = 0; s < N; s++) o_hits[s] = covers(s, px, py);
    for (int s = 0; s < N; s++) begin
      if (o_hits[s] && !o_on) begin
        o_on   = 1;
        o_slot = s;
        lx     = px - RB - m_ax[s];
        if (m_af[s]) lx = W - 1 - lx;
        ly     = py - m_ay[s];
        o_rgb  = (m_ao[s] + lx / 2 + ly / 4) % 8;
      end
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < N; s++) begin
      m_sx[s] = 0; m_sy[s] = 0; m_so[s] = 0; m_sv[s] = 0; m_sf[s] = 0;
      m_ax[s] = 0; m_ay[s] = 0; m_ao[s] = 0; m_av[s] = 0; m_af[s] = 0;
    end
    m_acc = '0; m_mask = '0; m_prev = '0;
    e1_on = 0; e1_slot = 0; e1_rgb = 0; e2_on = 0; e2_slot = 0; e2_rgb = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_on"}, int'(on), int'(e2_on));
    check({tag, "_hit_slot"}, int'(hit_slot), e2_slot);
    check({tag, "_rgb"}, int'(rgb), e2_rgb);
    check({tag, "_mask"}, int'(collision_mask), int'(m_mask));
    check({tag, "_collision"}, int'(collision), int'(|m_mask));
  endtask

  // One pixel clock: present inputs, advance DUT and model, compare away from the edge.
  task automatic step(input int px, input int py, input bit fs, input bit we, input int ws,
                      input int wx, input int wy, input int wo, input bit wv);
    bit [N-1:0] hv;
    pixel_x = 10'(px); pixel_y = 10'(py); frame_start = fs;
    wr_en = we; wr_slot = 2'(ws); wr_x = 8'(wx); wr_y = 10'(wy);
    wr_owner = 3'(wo); wr_visible = wv;
`ifdef CAR_FLIP_EN
    wr_flip = m_wflip;
`endif
    @(posedge pclk);
    if (fs) begin
      m_mask = m_acc | (($countones(m_prev) >= 2) ? m_prev : '0);
      m_acc  = '0;
    end else if ($countones(m_prev) >= 2) begin
      m_acc = m_acc | m_prev;
    end
    e2_on = e1_on; e2_slot = e1_slot; e2_rgb = e1_rgb;
    model_pixel(px, py, e1_on, e1_slot, e1_rgb, hv);
    m_prev = hv;
    if (fs) begin
      for (int s = 0; s < N; s++) begin
        m_ax[s] = m_sx[s]; m_ay[s] = m_sy[s]; m_ao[s] = m_so[s];
        m_av[s] = m_sv[s]; m_af[s] = m_sf[s];
      end
    end
    if (we && ws < N) begin
      m_sx[ws] = wx; m_sy[ws] = wy; m_so[ws] = wo; m_sv[ws] = wv;
`ifdef CAR_FLIP_EN
      m_sf[ws] = m_wflip;
`endif
    end
    #1;
    check_outputs("model");
  endtask

  task automatic idle(input int px, input int py, input bit fs);
    step(px, py, fs, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic write(input int ws, input int wx, input int wy, input int wo, input bit wv);
    step(0, 0, 1'b0, 1'b1, ws, wx, wy, wo, wv);
  endtask

  // Hold a pixel for two edges and compare against constant expectations.
  task automatic probe(input string name, input int px, input int py, input bit exp_on,
                       input int exp_slot);
    idle(px, py, 1'b0);
    idle(px, py, 1'b0);
    check({name, "_on"}, int'(on), int'(exp_on));
    check({name, "_slot"}, int'(hit_slot), exp_slot);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pixel_x = '0; pixel_y = '0; frame_start = 0; wr_en = 0; wr_slot = '0;
    wr_x = '0; wr_y = '0; wr_owner = '0; wr_visible = 0;
`ifdef CAR_FLIP_EN
    wr_flip = 0;
    m_wflip = 0;
`endif
    model_clear();
    repeat (2) @(posedge pclk);
    #1;
    check("reset_on", int'(on), 0);
    check("reset_rgb", int'(rgb), 0);
    check("reset_hit_slot", int'(hit_slot), 0);
    check("reset_mask", int'(collision_mask), 0);
    reset = 1'b0;
  endtask

  typedef struct {
    int px;
    int py;
    bit on;
    int slot;
    int rgb;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Slot0 at (40,100) owner 2; slot3 at (250,1000) owner 1.
    tbl[0]  = '{296, 100,  1, 0, 2};
    tbl[1]  = '{311, 131,  1, 0, 0};
    tbl[2]  = '{300, 115,  1, 0, 7};
    tbl[3]  = '{312, 100,  0, 0, 0};
    tbl[4]  = '{296, 132,  0, 0, 0};
    tbl[5]  = '{295, 100,  0, 0, 0};
    tbl[6]  = '{296, 99,   0, 0, 0};
    tbl[7]  = '{506, 1000, 1, 3, 1};
    tbl[8]  = '{511, 1023, 1, 3, 0};
    tbl[9]  = '{505, 1000, 0, 0, 0};
    tbl[10] = '{256, 1000, 0, 0, 0};
    tbl[11] = '{265, 1000, 0, 0, 0};
    tbl[12] = '{506, 0,    0, 0, 0};

    // 1: nothing written, coarse scan of the whole frame.
    do_reset();
    idle(0, 0, 1'b1);
    for (int y = 0; y < 1024; y += 37)
      for (int x = 0; x < 1024; x += 29) idle(x, y, 1'b0);
    check("empty_collision", int'(collision), 0);

    // 2 + 5: vector table.
    do_reset();
    write(0, 40, 100, 2, 1'b1);
    write(3, 250, 1000, 1, 1'b1);
    idle(0, 0, 1'b1);
    foreach (tbl[i]) begin
      idle(tbl[i].px, tbl[i].py, 1'b0);
      idle(tbl[i].px, tbl[i].py, 1'b0);
      check($sformatf("tbl%0d_on", i), int'(on), int'(tbl[i].on));
      check($sformatf("tbl%0d_slot", i), int'(hit_slot), tbl[i].slot);
      check($sformatf("tbl%0d_rgb", i), int'(rgb), tbl[i].rgb);
    end

    // 3: overlap, priority and collision mask lifetime.
    do_reset();
    write(1, 40, 100, 3, 1'b1);
    write(2, 48, 110, 5, 1'b1);
    idle(0, 0, 1'b1);
    probe("prio_single", 300, 115, 1'b1, 1);
    probe("prio_overlap", 306, 115, 1'b1, 1);
    idle(0, 0, 1'b0);
    idle(0, 0, 1'b1);
    check("coll_mask", int'(collision_mask), 4'b0110);
    check("coll_flag", int'(collision), 1);
    probe("coll_still", 306, 115, 1'b1, 1);
    write(2, 100, 300, 5, 1'b1);
    idle(0, 0, 1'b1);
    check("coll_mask_held", int'(collision_mask), 4'b0110);
    probe("moved_away", 306, 115, 1'b1, 1);
    idle(0, 0, 1'b0);
    idle(0, 0, 1'b1);
    check("coll_mask_clear", int'(collision_mask), 0);
    check("coll_flag_clear", int'(collision), 0);

    // 4: shadow writes only land at frame start.
    do_reset();
    write(0, 40, 100, 2, 1'b1);
    idle(0, 0, 1'b1);
    write(0, 60, 100, 2, 1'b1);
    probe("mid_old_on", 296, 100, 1'b1, 0);
    probe("mid_new_off", 316, 100, 1'b0, 0);
    idle(0, 0, 1'b1);
    probe("fs_new_on", 316, 100, 1'b1, 0);
    probe("fs_old_off", 296, 100, 1'b0, 0);
    step(0, 0, 1'b1, 1'b1, 0, 80, 100, 2, 1'b1);
    probe("coinc_keep", 316, 100, 1'b1, 0);
    probe("coinc_not_yet", 336, 100, 1'b0, 0);
    idle(0, 0, 1'b1);
    probe("coinc_landed", 336, 100, 1'b1, 0);

    // 6: reset in the middle of a scan with cars drawn and a live collision mask.
    write(1, 80, 105, 4, 1'b1);
    idle(0, 0, 1'b1);
    idle(340, 110, 1'b0);
    idle(0, 0, 1'b1);
    check("pre_reset_mask", int'(collision_mask), 4'b0011);
    idle(340, 110, 1'b0);
    idle(340, 110, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_on", int'(on), 0);
    check("midrst_rgb", int'(rgb), 0);
    check("midrst_mask", int'(collision_mask), 0);
    model_clear();
    @(posedge pclk);
    #1;
    reset = 1'b0;
    probe("post_reset", 340, 110, 1'b0, 0);
    write(0, 84, 100, 6, 1'b1);
    idle(0, 0, 1'b1);
    probe("post_reset_draw", 340, 110, 1'b1, 0);

`ifdef CAR_FLIP_EN
    do_reset();
    m_wflip = 1;
    write(0, 40, 100, 2, 1'b1);
    m_wflip = 0;
    idle(0, 0, 1'b1);
    probe("flip", 296, 100, 1'b1, 0);
    check("flip_rgb", int'(rgb), 1);
`endif

    // Randomized frames against the model.
    do_reset();
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 4; k++) begin
`ifdef CAR_FLIP_EN
        m_wflip = 1'($urandom_range(0, 1));
`endif
        step(256 + $urandom_range(0, 120), $urandom_range(70, 200), 1'b0, 1'b1,
             $urandom_range(0, N - 1), $urandom_range(20, 80), $urandom_range(80, 160),
             $urandom_range(0, 7), ($urandom_range(0, 3) != 0));
      end
      idle(256 + $urandom_range(0, 120), $urandom_range(70, 200), 1'b1);
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 9) == 0)
          step(256 + $urandom_range(0, 120), $urandom_range(70, 200), 1'b0, 1'b1,
               $urandom_range(0, N - 1), $urandom_range(20, 80), $urandom_range(80, 160),
               $urandom_range(0, 7), 1'b1);
        else
          idle(250 + $urandom_range(0, 130), $urandom_range(70, 200), 1'b0);
      end
    end
    idle(0, 0, 1'b1);
    idle(0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
